// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: FSM states, header field positions and memory targets shared by boot_loader
package boot_loader_pkg;
  typedef enum logic [2:0] {HDR, DATA, CSUM, HOLD, RUN, FAIL} state_e;
  typedef enum logic {TGT_IMEM, TGT_DMEM} tgt_e;
  localparam int TGT_BIT = 31;
  localparam int LAST_BIT = 30;
  localparam int CNT_HI = 29;
  localparam int CNT_LO = 15;
  localparam int BASE_HI = 14;
endpackage

// File: rtl/boot_loader.sv
// boot_loader: streams header+payload segments into imem/dmem then releases core reset; BOOT_LOADER_CSUM_EN adds a trailing checksum word
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
`ifdef BOOT_LOADER_CSUM_EN
  localparam state_e END_ST = CSUM;
  logic [DATA_W-1:0] sum_q;
`else
  localparam state_e END_ST = HOLD;
`endif
  state_e state_q, state_d;
  tgt_e tgt_q, tgt_d;
  logic last_q, last_d;
  logic [15:0] rem_q, rem_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic err_q, err_d, rdy_q;
  logic imem_we_q, dmem_we_q;
  logic [ADDR_W-1:0] imem_addr_q, dmem_addr_q;
  logic [DATA_W-1:0] imem_wdata_q, dmem_wdata_q;
  logic acc, wr, in_range;
  assign acc = in_valid && rdy_q;
  assign wr = acc && state_q == DATA;
  assign in_range = 32'(ptr_q) < (tgt_q == TGT_IMEM ? IMEM_WORDS : DMEM_WORDS);
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    last_d = last_q;
    rem_d = rem_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    err_d = err_q;
    case (state_q)
      HDR: if (acc) begin
        tgt_d = tgt_e'(in_data[TGT_BIT]);
        last_d = in_data[LAST_BIT];
        rem_d = 16'(in_data[CNT_HI:CNT_LO]) + 16'd1;
        ptr_d = {1'b0, ADDR_W'(in_data[BASE_HI:0])};
        state_d = DATA;
      end
      DATA: if (acc) begin
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 16'd1;
        err_d = err_q | ~in_range;
        if (rem_q == 16'd1) state_d = last_q ? END_ST : HDR;
      end
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = RUN;
      end
`ifdef BOOT_LOADER_CSUM_EN
      CSUM: if (acc) begin
        state_d = in_data == sum_q ? HOLD : FAIL;
        err_d = err_q | (in_data != sum_q);
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR;
      tgt_q <= TGT_IMEM;
      last_q <= 1'b0;
      rem_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      imem_wdata_q <= '0;
      dmem_wdata_q <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      last_q <= last_d;
      rem_q <= rem_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      err_q <= err_d;
      rdy_q <= state_d inside {HDR, DATA, CSUM};
      imem_we_q <= wr && in_range && tgt_q == TGT_IMEM;
      dmem_we_q <= wr && in_range && tgt_q == TGT_DMEM;
      if (wr && tgt_q == TGT_IMEM) begin
        imem_addr_q <= ptr_q[ADDR_W-1:0];
        imem_wdata_q <= in_data;
      end
      if (wr && tgt_q == TGT_DMEM) begin
        dmem_addr_q <= ptr_q[ADDR_W-1:0];
        dmem_wdata_q <= in_data;
      end
`ifdef BOOT_LOADER_CSUM_EN
      if (wr) sum_q <= sum_q + in_data;
`endif
    end
  end
  assign in_ready = rdy_q;
  assign imem_we = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign core_rst = state_q != RUN;
  assign done = state_q == RUN;
  assign err = err_q;
endmodule
